// File: rtl/chip8_pkg.sv
// Shared types and widths for the CHIP-8 scheduler and its timers.
package chip8_pkg;

    localparam int unsigned PEND_W = 3;
    localparam int unsigned TMR_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/chip8_countdown8.sv
// 8-bit down counter that holds at zero; a load overrides the tick.
module chip8_countdown8
    import chip8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    input  logic [TMR_W-1:0] wdata,
    output logic [TMR_W-1:0] value
);

    logic [TMR_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = wdata;
        end else if (tick && (value_q != '0)) begin
            value_d = value_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/chip8_sched.sv
// CHIP-8 instruction scheduler: queues CPU ticks, issues start strobes under a
// start/done handshake, handles run/halt/step, and owns the DT/ST timers.
module chip8_sched
    import chip8_pkg::*;
#(
    parameter int unsigned MAX_PENDING    = 3,
    parameter bit          FREEZE_ON_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              timer_cpu_tick,
    input  logic              timer_60hz_tick,
    input  logic              run_en,
    input  logic              step_req,
    input  logic              cpu_done,
    input  logic              dt_we,
    input  logic              st_we,
    input  logic [TMR_W-1:0]  wdata,
    input  logic              ovf_clr,
    output logic              cpu_step,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overrun,
    output logic [TMR_W-1:0]  dt_value,
    output logic [TMR_W-1:0]  st_value,
    output logic              sound_on
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    sched_state_e      state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              step_latch_q, step_latch_d;
    logic              cpu_step_q, cpu_step_d;
    logic              busy_q, busy_d;
    logic              issue_go;
    logic              tick_drop;
    logic              tmr_dec;

    // Next-state, queue and latch logic; strobes are registered from state_d.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        step_latch_d = step_latch_q;
        tick_drop    = 1'b0;

        issue_go = (state_q == IDLE) &&
                   ((run_en && (pending_q != '0)) || (!run_en && step_latch_q));

        case (state_q)
            IDLE:    if (issue_go) state_d = ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC:    if (cpu_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cpu_step_d = (state_d == ISSUE);
        busy_d     = (state_d == EXEC);

        // A tick and an issue in the same cycle cancel out.
        if (!run_en) begin
            pending_d = '0;
        end else if (timer_cpu_tick && !issue_go) begin
            if (pending_q == PEND_MAX) begin
                tick_drop = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (!timer_cpu_tick && issue_go) begin
            pending_d = pending_q - PEND_W'(1);
        end

        if (tick_drop) begin
            overrun_d = 1'b1;
        end else if (ovf_clr) begin
            overrun_d = 1'b0;
        end

        // Further step requests while one is being issued collapse into it.
        if (run_en || issue_go) begin
            step_latch_d = 1'b0;
        end else if (step_req) begin
            step_latch_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            overrun_q    <= 1'b0;
            step_latch_q <= 1'b0;
            cpu_step_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            step_latch_q <= step_latch_d;
            cpu_step_q   <= cpu_step_d;
            busy_q       <= busy_d;
        end
    end

    assign tmr_dec = timer_60hz_tick && !(FREEZE_ON_HALT && !run_en);

    chip8_countdown8 u_dt (
        .clk   (clk),
        .rst   (rst),
        .load  (dt_we),
        .tick  (tmr_dec),
        .wdata (wdata),
        .value (dt_value)
    );

    chip8_countdown8 u_st (
        .clk   (clk),
        .rst   (rst),
        .load  (st_we),
        .tick  (tmr_dec),
        .wdata (wdata),
        .value (st_value)
    );

    assign cpu_step = cpu_step_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overrun  = overrun_q;
    assign sound_on = (st_value != '0);

endmodule

// File: tb/tb_chip8_sched.sv
// Directed bench for chip8_sched; a second instance runs with FREEZE_ON_HALT=1.
module tb_chip8_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       timer_cpu_tick = 1'b0;
    logic       timer_60hz_tick = 1'b0;
    logic       run_en = 1'b0;
    logic       step_req = 1'b0;
    logic       cpu_done = 1'b0;
    logic       dt_we = 1'b0;
    logic       st_we = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic       ovf_clr = 1'b0;

    logic       cpu_step, busy, overrun, sound_on;
    logic [2:0] pending;
    logic [7:0] dt_value, st_value;

    logic       f_cpu_step, f_busy, f_overrun, f_sound_on;
    logic [2:0] f_pending;
    logic [7:0] f_dt_value, f_st_value;

    int errors = 0;
    int checks = 0;
    int unsigned step_cnt = 0;
    int unsigned base;

    always #5 clk = ~clk;

    chip8_sched #(.MAX_PENDING(3), .FREEZE_ON_HALT(1'b0)) dut (
        .clk(clk), .rst(rst), .timer_cpu_tick(timer_cpu_tick),
        .timer_60hz_tick(timer_60hz_tick), .run_en(run_en), .step_req(step_req),
        .cpu_done(cpu_done), .dt_we(dt_we), .st_we(st_we), .wdata(wdata),
        .ovf_clr(ovf_clr), .cpu_step(cpu_step), .busy(busy), .pending(pending),
        .overrun(overrun), .dt_value(dt_value), .st_value(st_value),
        .sound_on(sound_on)
    );

    chip8_sched #(.MAX_PENDING(3), .FREEZE_ON_HALT(1'b1)) dut_frz (
        .clk(clk), .rst(rst), .timer_cpu_tick(timer_cpu_tick),
        .timer_60hz_tick(timer_60hz_tick), .run_en(run_en), .step_req(step_req),
        .cpu_done(cpu_done), .dt_we(dt_we), .st_we(st_we), .wdata(wdata),
        .ovf_clr(ovf_clr), .cpu_step(f_cpu_step), .busy(f_busy),
        .pending(f_pending), .overrun(f_overrun), .dt_value(f_dt_value),
        .st_value(f_st_value), .sound_on(f_sound_on)
    );

    // Counts instruction-start strobes of the main instance.
    always @(posedge clk) if (cpu_step) step_cnt <= step_cnt + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_cpu_step", 32'(cpu_step), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_dt", 32'(dt_value), 0);
        chk("rst_st", 32'(st_value), 0);
        chk("rst_sound", 32'(sound_on), 0);

        // Single tick, done 3 cycles after the strobe
        run_en = 1'b1;
        timer_cpu_tick = 1'b1; cyc(); timer_cpu_tick = 1'b0;
        chk("t1_pending_n1", 32'(pending), 1);
        chk("t1_step_n1", 32'(cpu_step), 0);
        cyc();
        chk("t1_step_n2", 32'(cpu_step), 1);
        chk("t1_pending_n2", 32'(pending), 0);
        chk("t1_busy_issue", 32'(busy), 0);
        cyc();
        chk("t1_busy_1", 32'(busy), 1);
        chk("t1_step_off", 32'(cpu_step), 0);
        cyc();
        chk("t1_busy_2", 32'(busy), 1);
        cyc();
        chk("t1_busy_3", 32'(busy), 1);
        cpu_done = 1'b1; cyc(); cpu_done = 1'b0;
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_overrun", 32'(overrun), 0);

        // Saturation while an instruction is held in EXEC
        timer_cpu_tick = 1'b1; cyc(); timer_cpu_tick = 1'b0;
        cyc(); cyc();
        chk("t2_exec", 32'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            timer_cpu_tick = 1'b1; cyc();
            chk($sformatf("t2_pending_%0d", i), 32'(pending), (i < 3) ? i + 1 : 3);
            chk($sformatf("t2_overrun_%0d", i), 32'(overrun), (i >= 3) ? 1 : 0);
        end
        timer_cpu_tick = 1'b0;
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("t2_ovf_clr", 32'(overrun), 0);
        base = step_cnt;
        for (int k = 0; k < 3; k++) begin
            cpu_done = 1'b1; cyc(); cpu_done = 1'b0;
            chk($sformatf("t2_idle_%0d", k), 32'(busy), 0);
            cyc();
            chk($sformatf("t2_strobe_%0d", k), 32'(cpu_step), 1);
            cyc();
        end
        chk("t2_steps", step_cnt - base, 3);
        chk("t2_pending_end", 32'(pending), 0);
        cpu_done = 1'b1; cyc(); cpu_done = 1'b0;
        cyc(); cyc(); cyc();
        chk("t2_no_extra", step_cnt - base, 3);
        chk("t2_idle_end", 32'(busy), 0);

        // Halted single-step
        run_en = 1'b0;
        base = step_cnt;
        timer_cpu_tick = 1'b1; step_req = 1'b1; cyc();
        chk("t3_pending_halt", 32'(pending), 0);
        cyc();
        timer_cpu_tick = 1'b0; step_req = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("t3_one_step", step_cnt - base, 1);
        chk("t3_pending", 32'(pending), 0);
        chk("t3_busy", 32'(busy), 1);
        cpu_done = 1'b1; cyc(); cpu_done = 1'b0;
        step_req = 1'b1; cyc(); step_req = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("t3_two_steps", step_cnt - base, 2);
        cpu_done = 1'b1; cyc(); cpu_done = 1'b0;
        cyc();

        // Sound timer countdown and write-over-tick priority
        run_en = 1'b1;
        st_we = 1'b1; wdata = 8'd3; cyc(); st_we = 1'b0;
        chk("t4_st_load", 32'(st_value), 3);
        chk("t4_sound_on", 32'(sound_on), 1);
        for (int i = 0; i < 4; i++) begin
            timer_60hz_tick = 1'b1; cyc();
            chk($sformatf("t4_st_%0d", i), 32'(st_value), (i < 2) ? 2 - i : 0);
            chk($sformatf("t4_sound_%0d", i), 32'(sound_on), (i < 2) ? 1 : 0);
        end
        dt_we = 1'b1; wdata = 8'd5; cyc();
        dt_we = 1'b0; timer_60hz_tick = 1'b0;
        chk("t4_dt_write_wins", 32'(dt_value), 5);

        // Freeze while halted
        dt_we = 1'b1; wdata = 8'd10; run_en = 1'b0; cyc(); dt_we = 1'b0;
        timer_60hz_tick = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        timer_60hz_tick = 1'b0;
        chk("t5_frz_hold", 32'(f_dt_value), 10);
        chk("t5_nofrz_dec", 32'(dt_value), 6);
        run_en = 1'b1;
        timer_60hz_tick = 1'b1; cyc(); cyc(); timer_60hz_tick = 1'b0;
        chk("t5_frz_run", 32'(f_dt_value), 8);
        chk("t5_nofrz_run", 32'(dt_value), 4);

        // Reset mid-EXEC
        dt_we = 1'b1; wdata = 8'd7; cyc(); dt_we = 1'b0;
        timer_cpu_tick = 1'b1; cyc(); timer_cpu_tick = 1'b0;
        cyc(); cyc();
        timer_cpu_tick = 1'b1; cyc(); cyc(); timer_cpu_tick = 1'b0;
        chk("t6_pre_pending", 32'(pending), 2);
        chk("t6_pre_busy", 32'(busy), 1);
        chk("t6_pre_dt", 32'(dt_value), 7);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t6_pending", 32'(pending), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_dt", 32'(dt_value), 0);
        chk("t6_step", 32'(cpu_step), 0);
        chk("t6_overrun", 32'(overrun), 0);
        base = step_cnt;
        cpu_done = 1'b1; cyc(); cpu_done = 1'b0;
        cyc(); cyc();
        chk("t6_late_done_busy", 32'(busy), 0);
        chk("t6_late_done_steps", step_cnt - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
